// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp
// Multi-read-port general register file for the 24-bit CPU datapath.
//   - NUM_READ combinational read ports, one synchronous write port
//   - register 0 hardwired to zero, optional same-cycle write forwarding
//   - 2*DATA_WIDTH multiply result register (MULREG) read out as HI/LO
//   - sequential bulk-clear engine (one register per cycle, Busy while active)
//
// Ports
//   Clock      in   rising-edge clock
//   ResetN     in   asynchronous active-low reset
//   ReadAddr   in   packed read addresses, port k = [k*AW +: AW]
//   ReadData   out  packed read data,      port k = [k*DW +: DW]
//   WriteAddr  in   write index
//   WriteData  in   write data
//   RegWrite   in   write enable (ignored while clearing)
//   MulWrite   in   load MULREG from MulData (accepted in any state)
//   MulData    in   multiplier product
//   MulHi      out  MULREG upper half
//   MulLo      out  MULREG lower half
//   ClearReq   in   start a bulk clear (ignored while clearing)
//   Busy       out  clear engine active
// ---------------------------------------------------------------------------
module reg_file_mp #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_READ   = 2,
    parameter int BYPASS     = 1
) (
    input  logic                             Clock,
    input  logic                             ResetN,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]   ReadAddr,
    output logic [NUM_READ*DATA_WIDTH-1:0]   ReadData,
    input  logic [ADDR_WIDTH-1:0]            WriteAddr,
    input  logic [DATA_WIDTH-1:0]            WriteData,
    input  logic                             RegWrite,
    input  logic                             MulWrite,
    input  logic [2*DATA_WIDTH-1:0]          MulData,
    output logic [DATA_WIDTH-1:0]            MulHi,
    output logic [DATA_WIDTH-1:0]            MulLo,
    input  logic                             ClearReq,
    output logic                             Busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam bit BYP_ON = (BYPASS != 0);

    localparam logic [ADDR_WIDTH-1:0] IDX_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] IDX_LAST = {ADDR_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    clr_idx_q, clr_idx_d;
    logic                     busy_q, busy_d;
    logic [DATA_WIDTH-1:0]    regs_q [DEPTH];
    logic [2*DATA_WIDTH-1:0]  mul_q;

    logic                     wr_en_s;
    logic                     clr_en_s;
    logic                     byp_en_s;

    // Writes to index 0 are dropped so the zero register never leaves reset value.
    assign wr_en_s  = RegWrite && (state_q == ST_IDLE) && (WriteAddr != IDX_ZERO);
    assign clr_en_s = (state_q == ST_CLEAR);
    // Forwarding is gated by ResetN so every read port shows 0 while reset is held.
    assign byp_en_s = BYP_ON && ResetN && RegWrite && (state_q == ST_IDLE);

    // Clear-engine next-state logic.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        busy_d    = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (ClearReq) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = IDX_ZERO;
                    busy_d    = 1'b1;
                end else begin
                    busy_d    = 1'b0;
                end
            end
            ST_CLEAR: begin
                // Index wraps to zero on the last step, ready for the next clear.
                clr_idx_d = clr_idx_q + IDX_ONE;
                if (clr_idx_q == IDX_LAST) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                clr_idx_d = IDX_ZERO;
                busy_d    = 1'b0;
            end
        endcase
    end

    // Clear-engine state, index and Busy registers.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q   <= ST_IDLE;
            clr_idx_q <= IDX_ZERO;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            busy_q    <= busy_d;
        end
    end

    // Register array: clear step has priority over the (already gated) write.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= DATA_ZERO;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (clr_en_s && (clr_idx_q == ADDR_WIDTH'(i))) begin
                    regs_q[i] <= DATA_ZERO;
                end else if (wr_en_s && (WriteAddr == ADDR_WIDTH'(i))) begin
                    regs_q[i] <= WriteData;
                end else begin
                    regs_q[i] <= regs_q[i];
                end
            end
        end
    end

    // Multiply result register, independent of the clear engine.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            mul_q <= {(2*DATA_WIDTH){1'b0}};
        end else if (MulWrite) begin
            mul_q <= MulData;
        end else begin
            mul_q <= mul_q;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr_s;
        logic [DATA_WIDTH-1:0] data_s;

        assign addr_s = ReadAddr[k*ADDR_WIDTH +: ADDR_WIDTH];

        // Read port mux: zero register, then forwarded write data, then array.
        always_comb begin
            data_s = DATA_ZERO;
            if (addr_s == IDX_ZERO) begin
                data_s = DATA_ZERO;
            end else if (byp_en_s && (WriteAddr == addr_s)) begin
                data_s = WriteData;
            end else begin
                data_s = regs_q[addr_s];
            end
        end

        assign ReadData[k*DATA_WIDTH +: DATA_WIDTH] = data_s;
    end

    assign MulHi = mul_q[2*DATA_WIDTH-1:DATA_WIDTH];
    assign MulLo = mul_q[DATA_WIDTH-1:0];
    assign Busy  = busy_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// ---------------------------------------------------------------------------
// tb_reg_file_mp
// Scoreboard bench for reg_file_mp. Three instances share clock and reset:
//   dut    default parameters (BYPASS=1, 2 ports, 16 regs)
//   dut_nb BYPASS=0, same inputs as dut
//   dut_w  NUM_READ=3, ADDR_WIDTH=5
// Stimulus sets inputs just after a rising edge and queues expected outputs;
// the monitor drains the queue on the following falling edge.
// ---------------------------------------------------------------------------
module tb_reg_file_mp;

    localparam int K_RD0 = 0, K_RD1 = 1, K_MULHI = 2, K_MULLO = 3, K_BUSY = 4,
                   K_NB_RD0 = 5, K_W_RD0 = 6, K_W_RD1 = 7, K_W_RD2 = 8,
                   K_W_BUSY = 9, K_W_MULLO = 10;

    typedef struct {
        int          kind;
        logic [47:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic        clk = 1'b1;
    logic        rst_n;
    logic [7:0]  rd_addr;
    logic [47:0] rd_data;
    logic [47:0] nb_rd_data;
    logic [3:0]  wr_addr;
    logic [23:0] wr_data;
    logic        reg_write;
    logic        mul_write;
    logic [47:0] mul_data;
    logic [23:0] mul_hi, mul_lo, nb_mul_hi, nb_mul_lo;
    logic        clear_req;
    logic        busy, nb_busy;

    logic [14:0] w_rd_addr;
    logic [71:0] w_rd_data;
    logic [4:0]  w_wr_addr;
    logic [23:0] w_wr_data;
    logic        w_reg_write;
    logic        w_clear_req;
    logic [23:0] w_mul_hi, w_mul_lo;
    logic        w_busy;

    always #5 clk = ~clk;

    reg_file_mp dut (
        .Clock(clk), .ResetN(rst_n), .ReadAddr(rd_addr), .ReadData(rd_data),
        .WriteAddr(wr_addr), .WriteData(wr_data), .RegWrite(reg_write),
        .MulWrite(mul_write), .MulData(mul_data), .MulHi(mul_hi), .MulLo(mul_lo),
        .ClearReq(clear_req), .Busy(busy)
    );

    reg_file_mp #(.BYPASS(0)) dut_nb (
        .Clock(clk), .ResetN(rst_n), .ReadAddr(rd_addr), .ReadData(nb_rd_data),
        .WriteAddr(wr_addr), .WriteData(wr_data), .RegWrite(reg_write),
        .MulWrite(mul_write), .MulData(mul_data), .MulHi(nb_mul_hi), .MulLo(nb_mul_lo),
        .ClearReq(clear_req), .Busy(nb_busy)
    );

    reg_file_mp #(.NUM_READ(3), .ADDR_WIDTH(5)) dut_w (
        .Clock(clk), .ResetN(rst_n), .ReadAddr(w_rd_addr), .ReadData(w_rd_data),
        .WriteAddr(w_wr_addr), .WriteData(w_wr_data), .RegWrite(w_reg_write),
        .MulWrite(1'b0), .MulData(48'h0), .MulHi(w_mul_hi), .MulLo(w_mul_lo),
        .ClearReq(w_clear_req), .Busy(w_busy)
    );

    function automatic void expect_out(int kind, logic [47:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        sb_q.push_back(e);
    endfunction

    function automatic logic [47:0] actual(int kind);
        case (kind)
            K_RD0:     return {24'h0, rd_data[23:0]};
            K_RD1:     return {24'h0, rd_data[47:24]};
            K_MULHI:   return {24'h0, mul_hi};
            K_MULLO:   return {24'h0, mul_lo};
            K_BUSY:    return {47'h0, busy};
            K_NB_RD0:  return {24'h0, nb_rd_data[23:0]};
            K_W_RD0:   return {24'h0, w_rd_data[23:0]};
            K_W_RD1:   return {24'h0, w_rd_data[47:24]};
            K_W_RD2:   return {24'h0, w_rd_data[71:48]};
            K_W_BUSY:  return {47'h0, w_busy};
            K_W_MULLO: return {24'h0, w_mul_lo};
            default:   return 48'hDEAD_DEAD_DEAD;
        endcase
    endfunction

    function automatic string kname(int kind);
        case (kind)
            K_RD0:     return "rd0";
            K_RD1:     return "rd1";
            K_MULHI:   return "mulhi";
            K_MULLO:   return "mullo";
            K_BUSY:    return "busy";
            K_NB_RD0:  return "nb_rd0";
            K_W_RD0:   return "w_rd0";
            K_W_RD1:   return "w_rd1";
            K_W_RD2:   return "w_rd2";
            K_W_BUSY:  return "w_busy";
            K_W_MULLO: return "w_mullo";
            default:   return "unknown";
        endcase
    endfunction

    // Monitor: compare every queued expectation against the live outputs.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t  e;
            logic [47:0] a;
            e = sb_q.pop_front();
            a = actual(e.kind);
            n_checks++;
            if (a !== e.val) begin
                n_fail++;
                $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", kname(e.kind), $time, a, e.val);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reg_write   = 1'b0;
        mul_write   = 1'b0;
        clear_req   = 1'b0;
        w_reg_write = 1'b0;
        w_clear_req = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [23:0] d);
        reg_write = 1'b1;
        wr_addr   = a;
        wr_data   = d;
        step();
        reg_write = 1'b0;
    endtask

    initial begin
        // Reset held with a live write request: all outputs must read 0.
        rst_n = 1'b0;
        idle_inputs();
        reg_write = 1'b1; wr_addr = 4'd5; wr_data = 24'h123456;
        rd_addr = {4'd5, 4'd5}; mul_data = 48'h0;
        w_rd_addr = {5'd31, 5'd31, 5'd31}; w_wr_addr = 5'd31; w_wr_data = 24'h0A0A0A;
        w_reg_write = 1'b1;
        expect_out(K_RD0, 48'h0); expect_out(K_RD1, 48'h0);
        expect_out(K_MULHI, 48'h0); expect_out(K_MULLO, 48'h0);
        expect_out(K_BUSY, 48'h0); expect_out(K_W_BUSY, 48'h0);
        expect_out(K_W_RD0, 48'h0); expect_out(K_W_MULLO, 48'h0);
        step();
        rst_n = 1'b1;
        idle_inputs();
        step();

        // Write R5, forwarded same cycle on both ports, stored afterwards.
        reg_write = 1'b1; wr_addr = 4'd5; wr_data = 24'h123456; rd_addr = {4'd5, 4'd5};
        expect_out(K_RD0, 48'h123456); expect_out(K_RD1, 48'h123456);
        expect_out(K_NB_RD0, 48'h0);
        step();
        reg_write = 1'b0;
        expect_out(K_RD0, 48'h123456); expect_out(K_RD1, 48'h123456);
        expect_out(K_NB_RD0, 48'h123456);
        step();
        // Write to R0 is discarded and never forwarded.
        reg_write = 1'b1; wr_addr = 4'd0; wr_data = 24'hFFFFFF; rd_addr = {4'd5, 4'd0};
        expect_out(K_RD0, 48'h0); expect_out(K_NB_RD0, 48'h0); expect_out(K_RD1, 48'h123456);
        step();
        reg_write = 1'b0;
        expect_out(K_RD0, 48'h0);
        step();

        // Bypass vs no bypass on R3.
        reg_write = 1'b1; wr_addr = 4'd3; wr_data = 24'hABCDEF; rd_addr = {4'd5, 4'd3};
        expect_out(K_RD0, 48'hABCDEF); expect_out(K_NB_RD0, 48'h0);
        step();
        reg_write = 1'b0;
        expect_out(K_RD0, 48'hABCDEF); expect_out(K_NB_RD0, 48'hABCDEF);
        step();

        // Fill R1..R15 with their index, then bulk clear.
        for (int k = 1; k < 16; k++) begin
            do_write(4'(k), 24'(k));
        end
        rd_addr = {4'd1, 4'd15};
        expect_out(K_RD0, 48'h00000F); expect_out(K_RD1, 48'h000001);
        step();
        clear_req = 1'b1; rd_addr = {4'd1, 4'd7};
        expect_out(K_BUSY, 48'h0);
        step();
        for (int i = 0; i < 16; i++) begin
            clear_req = (i < 8);
            reg_write = (i == 3); wr_addr = 4'd7; wr_data = 24'h111111;
            mul_write = (i == 5); mul_data = 48'h00ABCD_001234;
            expect_out(K_BUSY, 48'h1);
            // R1 is zeroed on the 2nd clear step, R7 on the 8th.
            expect_out(K_RD1, (i >= 2) ? 48'h0 : 48'h1);
            expect_out(K_RD0, (i >= 8) ? 48'h0 : 48'h7);
            if (i == 6) begin
                expect_out(K_MULHI, 48'h00ABCD); expect_out(K_MULLO, 48'h001234);
            end
            step();
        end
        idle_inputs();
        expect_out(K_BUSY, 48'h0);
        for (int k = 0; k < 16; k++) begin
            rd_addr = {4'(15 - k), 4'(k)};
            expect_out(K_RD0, 48'h0); expect_out(K_RD1, 48'h0);
            step();
        end

        // Simultaneous MulWrite and RegWrite.
        mul_write = 1'b1; mul_data = 48'h000001_FFFFFE;
        reg_write = 1'b1; wr_addr = 4'd2; wr_data = 24'h222222; rd_addr = {4'd0, 4'd2};
        expect_out(K_MULHI, 48'h00ABCD); expect_out(K_MULLO, 48'h001234);
        expect_out(K_RD0, 48'h222222); expect_out(K_RD1, 48'h0);
        step();
        idle_inputs();
        expect_out(K_MULHI, 48'h000001); expect_out(K_MULLO, 48'hFFFFFE);
        expect_out(K_RD0, 48'h222222);
        step();

        // Reset in the middle of a clear.
        do_write(4'd9, 24'h000099);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            expect_out(K_BUSY, 48'h1);
            step();
        end
        rst_n = 1'b0;
        #1;
        rd_addr = {4'd2, 4'd9};
        expect_out(K_RD0, 48'h0); expect_out(K_RD1, 48'h0);
        expect_out(K_MULHI, 48'h0); expect_out(K_MULLO, 48'h0);
        expect_out(K_BUSY, 48'h0); expect_out(K_W_BUSY, 48'h0);
        step();
        rst_n = 1'b1;
        expect_out(K_BUSY, 48'h0); expect_out(K_RD0, 48'h0);
        step();
        do_write(4'd1, 24'h000011);
        do_write(4'd2, 24'h000022);
        clear_req = 1'b1; rd_addr = {4'd2, 4'd1};
        step();
        clear_req = 1'b0;
        // A clear restarting at index 0 zeroes R1 after 2 steps, R2 after 3.
        for (int i = 0; i < 16; i++) begin
            expect_out(K_BUSY, 48'h1);
            expect_out(K_RD0, (i >= 2) ? 48'h0 : 48'h11);
            expect_out(K_RD1, (i >= 3) ? 48'h0 : 48'h22);
            step();
        end
        expect_out(K_BUSY, 48'h0);
        step();

        // Wide instance: 3 ports, 32 registers.
        w_reg_write = 1'b1; w_wr_addr = 5'd31; w_wr_data = 24'h0A0A0A;
        w_rd_addr = {5'd31, 5'd31, 5'd31};
        expect_out(K_W_RD0, 48'h0A0A0A); expect_out(K_W_RD1, 48'h0A0A0A); expect_out(K_W_RD2, 48'h0A0A0A);
        step();
        w_reg_write = 1'b0;
        expect_out(K_W_RD0, 48'h0A0A0A); expect_out(K_W_RD1, 48'h0A0A0A); expect_out(K_W_RD2, 48'h0A0A0A);
        step();
        w_clear_req = 1'b1;
        expect_out(K_W_BUSY, 48'h0);
        step();
        w_clear_req = 1'b0;
        for (int i = 0; i < 32; i++) begin
            expect_out(K_W_BUSY, 48'h1);
            expect_out(K_W_RD2, 48'h0A0A0A);
            step();
        end
        expect_out(K_W_BUSY, 48'h0); expect_out(K_W_RD2, 48'h0);
        step();

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
